// File: rtl/mbu_banked_if.sv
// Bus bundle between the CU decode / IBus side and the memory bank unit.
// The slave modport is the bank unit; the master modport is the CU/IBus side driving it.
interface mbu_banked_if #(
    parameter int NREGS  = 8,
    parameter int BANK_W = 8,
    parameter int IBUS_W = 16
) ();
    localparam int IDXW = $clog2(NREGS);

    logic [4:0]        raddr;
    logic [4:0]        waddr;
    logic [IBUS_W-1:0] ibus_in;
    logic [IBUS_W-1:0] ibus_out;
    logic              ibus_oe;
    logic              ir_idx;
    logic [IDXW-1:0]   ir;
    logic              fp_rom;
    logic [BANK_W-1:0] aext;
    logic              war;
    logic              busy;

    modport slave (
        input  raddr, waddr, ibus_in, ir_idx, ir, fp_rom,
        output ibus_out, ibus_oe, aext, war, busy
    );

    modport master (
        output raddr, waddr, ibus_in, ir_idx, ir, fp_rom,
        input  ibus_out, ibus_oe, aext, war, busy
    );
endinterface

// File: rtl/mbu_banked.sv
// Banked memory unit: NCTX x NREGS bank registers feeding a registered AEXT,
// with a context-clear sequencer and a gate holding AEXT at its default until the first bank write.
//
// state | meaning
// IDLE  | accepts MBn/MBP/CTX/CLRCTX writes, busy=0
// CLEAR | zeroes one entry of clr_ctx per cycle, writes dropped, busy=1
module mbu_banked #(
    parameter int NREGS  = 8,
    parameter int NCTX   = 32,
    parameter int BANK_W = 8,
    parameter int IBUS_W = 16
) (
    input  logic        clk4,
    input  logic        rsthold,
    mbu_banked_if.slave bus
);
    localparam int IDXW = $clog2(NREGS);
    localparam int CTXW = $clog2(NCTX);

    localparam logic [4:0] A_MBN  = 5'd27;
    localparam logic [4:0] A_MBP  = 5'd28;
    localparam logic [4:0] A_CTX0 = 5'd29;
    localparam logic [4:0] A_CTX1 = 5'd30;
    localparam logic [4:0] A_CLR  = 5'd31;

    localparam logic [IDXW-1:0] IDX0     = '0;
    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t state_q, state_d;

    logic [BANK_W-1:0] mem [NCTX][NREGS];
    logic [CTXW-1:0]   ctx;
    logic [CTXW-1:0]   clr_ctx;
    logic [IDXW-1:0]   cnt;
    logic              en;
    logic              ir_idx_r;
    logic [BANK_W-1:0] aext;
    logic              busy;
    logic              clr_we;
    logic [IBUS_W-1:0] ibus_out;
    logic              ibus_oe;

    logic rd_mbn, rd_mbp, rd_ctx;
    logic wr_mbn, wr_mbp, wr_ctx, wr_clr;
    logic idle;
    logic war;
    logic [BANK_W-1:0] def_val;
    logic [IDXW-1:0]   idx_ar;
    logic              unused_ibus_hi;

    assign rd_mbn = (bus.raddr == A_MBN);
    assign rd_mbp = (bus.raddr == A_MBP);
    assign rd_ctx = (bus.raddr == A_CTX0) || (bus.raddr == A_CTX1);
    assign wr_mbn = (bus.waddr == A_MBN);
    assign wr_mbp = (bus.waddr == A_MBP);
    assign wr_ctx = (bus.waddr == A_CTX0) || (bus.waddr == A_CTX1);
    assign wr_clr = (bus.waddr == A_CLR);

    assign idle    = (state_q == IDLE);
    assign war     = (bus.waddr[4:2] == 3'b001);
    assign def_val = {bus.fp_rom, {(BANK_W-1){1'b0}}};
    // The index source is sampled a cycle early so the CU can set it ahead of the AR write.
    assign idx_ar  = ir_idx_r ? bus.ir : IDXW'(bus.raddr[1:0]);

    assign unused_ibus_hi = ^bus.ibus_in[IBUS_W-1:BANK_W];

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_clr) state_d = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == CNT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk4) begin
        if (rsthold) begin
            state_q  <= IDLE;
            ctx      <= '0;
            clr_ctx  <= '0;
            cnt      <= '0;
            en       <= 1'b0;
            ir_idx_r <= 1'b0;
            aext     <= def_val;
        end else begin
            state_q  <= state_d;
            ir_idx_r <= bus.ir_idx;
            if (idle && (wr_mbn || wr_mbp)) en <= 1'b1;
            if (idle && wr_ctx) ctx <= bus.ibus_in[CTXW-1:0];
            if (idle && wr_clr) begin
                clr_ctx <= bus.ibus_in[CTXW-1:0];
                cnt     <= '0;
            end else if (clr_we) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + IDXW'(1);
            end
            // No write bypass: AEXT takes the pre-edge storage content.
            if (war) aext <= en ? mem[ctx][idx_ar] : def_val;
        end
    end

    // Storage has no reset; reset only suppresses writes on the edge it is held.
    always_ff @(posedge clk4) begin
        if (!rsthold) begin
            if (clr_we)
                mem[clr_ctx][cnt] <= '0;
            else if (idle && wr_mbn)
                mem[ctx][bus.ir] <= bus.ibus_in[BANK_W-1:0];
            else if (idle && wr_mbp)
                mem[ctx][IDX0] <= bus.ibus_in[BANK_W-1:0];
        end
    end

    always_comb begin
        ibus_oe  = 1'b0;
        ibus_out = '0;
        if (rd_mbn) begin
            ibus_oe  = 1'b1;
            ibus_out = IBUS_W'(en ? mem[ctx][bus.ir] : def_val);
        end else if (rd_mbp) begin
            ibus_oe  = 1'b1;
            ibus_out = IBUS_W'(en ? mem[ctx][IDX0] : def_val);
        end else if (rd_ctx) begin
            ibus_oe  = 1'b1;
            ibus_out = IBUS_W'(ctx);
        end
    end

    assign bus.ibus_out = ibus_out;
    assign bus.ibus_oe  = ibus_oe;
    assign bus.aext     = aext;
    assign bus.war      = war;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_mbu_banked.sv
// Scoreboard bench for mbu_banked: the driver predicts responses from a register-array model,
// a separate monitor compares them as the DUT presents reads, AEXT updates and busy/war status.
module tb_mbu_banked;
    logic clk4 = 1'b0;
    logic rsthold;
    logic fp_rom;

    always #5 clk4 = ~clk4;

    mbu_banked_if #(.NREGS(8), .BANK_W(8), .IBUS_W(16)) bus ();

    mbu_banked #(.NREGS(8), .NCTX(32), .BANK_W(8), .IBUS_W(16)) dut (
        .clk4    (clk4),
        .rsthold (rsthold),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] v;
        bit          known;
    } exp_t;

    typedef struct {
        bit busy;
        bit war;
    } st_t;

    exp_t rd_q[$];
    exp_t aext_q[$];
    st_t  st_q[$];

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_mem   [32][8];
    bit         m_known [32][8];
    int         m_ctx;
    bit         m_en;
    bit         m_irx;
    bit         m_clr;
    int         m_cc;
    int         m_pos;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t bank_read(input int c, input int i, input logic [7:0] def);
        exp_t e;
        if (m_en) begin
            e.v     = {8'h00, m_mem[c][i]};
            e.known = m_known[c][i];
        end else begin
            e.v     = {8'h00, def};
            e.known = 1'b1;
        end
        return e;
    endfunction

    // One bus cycle: drive at negedge, predict against pre-edge model state, then advance the model.
    task automatic cyc(input logic [4:0] ra, input logic [4:0] wa, input logic [15:0] d,
                       input bit irx, input logic [2:0] irv, input bit rst);
        exp_t       e;
        st_t        s;
        logic [7:0] def;
        int         idx;
        @(negedge clk4);
        bus.raddr   = ra;
        bus.waddr   = wa;
        bus.ibus_in = d;
        bus.ir_idx  = irx;
        bus.ir      = irv;
        bus.fp_rom  = fp_rom;
        rsthold     = rst;
        def = {fp_rom, 7'b0};

        s.busy = m_clr;
        s.war  = (wa >= 5'd4) && (wa <= 5'd7);
        st_q.push_back(s);

        if (ra == 5'd27) rd_q.push_back(bank_read(m_ctx, int'(irv), def));
        else if (ra == 5'd28) rd_q.push_back(bank_read(m_ctx, 0, def));
        else if (ra == 5'd29 || ra == 5'd30) begin
            e.v = 16'(m_ctx);
            e.known = 1'b1;
            rd_q.push_back(e);
        end

        if (s.war) begin
            idx = m_irx ? int'(irv) : int'(ra[1:0]);
            if (rst) begin
                e.v = {8'h00, def};
                e.known = 1'b1;
            end else begin
                e = bank_read(m_ctx, idx, def);
            end
            aext_q.push_back(e);
        end

        if (rst) begin
            m_ctx = 0; m_en = 0; m_irx = 0; m_clr = 0; m_pos = 0;
        end else begin
            if (m_clr) begin
                m_mem[m_cc][m_pos]   = 8'h00;
                m_known[m_cc][m_pos] = 1'b1;
                m_pos++;
                if (m_pos == 8) m_clr = 0;
            end else begin
                case (wa)
                    5'd27: begin
                        m_mem[m_ctx][irv] = d[7:0]; m_known[m_ctx][irv] = 1'b1; m_en = 1;
                    end
                    5'd28: begin
                        m_mem[m_ctx][0] = d[7:0]; m_known[m_ctx][0] = 1'b1; m_en = 1;
                    end
                    5'd29, 5'd30: m_ctx = int'(d) % 32;
                    5'd31: begin
                        m_clr = 1; m_cc = int'(d) % 32; m_pos = 0;
                    end
                    default: ;
                endcase
            end
            m_irx = irx;
        end
    endtask

    // Monitor: consumes one status entry per driven cycle.
    initial begin
        st_t  s;
        exp_t e;
        bit   pend;
        forever begin
            @(negedge clk4);
            #2;
            pend = 1'b0;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("busy", 16'(bus.busy), 16'(s.busy));
                chk("war", 16'(bus.war), 16'(s.war));
                if (bus.ibus_oe) begin
                    if (rd_q.size() == 0) chk("unexpected_oe", 16'(bus.ibus_oe), 16'h0000);
                    else begin
                        e = rd_q.pop_front();
                        if (e.known) chk("ibus_out", bus.ibus_out, e.v);
                    end
                end
                if (bus.war) begin
                    if (aext_q.size() == 0) chk("unexpected_war", 16'(bus.war), 16'h0000);
                    else begin
                        e = aext_q.pop_front();
                        pend = e.known;
                    end
                end
            end
            @(posedge clk4);
            #1;
            if (pend) chk("aext", 16'(bus.aext), e.v);
        end
    end

    initial begin
        logic [4:0]  ra_tab [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd27, 5'd28, 5'd29, 5'd30};
        logic [4:0]  ra, wa;
        logic [15:0] d;
        int          r;

        m_ctx = 0; m_en = 0; m_irx = 0; m_clr = 0; m_cc = 0; m_pos = 0;
        for (int c = 0; c < 32; c++)
            for (int i = 0; i < 8; i++) begin
                m_mem[c][i] = 8'h00;
                m_known[c][i] = 1'b0;
            end
        fp_rom = 1'b1;
        rsthold = 1'b1;
        bus.raddr = '0; bus.waddr = '0; bus.ibus_in = '0;
        bus.ir_idx = 1'b0; bus.ir = '0; bus.fp_rom = 1'b1;

        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        @(posedge clk4);
        #1;
        chk("rst_aext", 16'(bus.aext), 16'h0080);
        chk("rst_busy", 16'(bus.busy), 16'h0000);
        chk("rst_oe", 16'(bus.ibus_oe), 16'h0000);

        // Default AEXT before any bank write; MBn read returns the default too.
        cyc(0, 5, 0, 0, 0, 0);
        cyc(27, 0, 0, 0, 3, 0);
        // CTX=3, MBP=0x12, then AR write.
        cyc(0, 29, 16'h0003, 0, 0, 0);
        cyc(0, 28, 16'h0012, 0, 0, 0);
        cyc(0, 4, 0, 0, 0, 0);
        cyc(29, 0, 0, 0, 0, 0);
        // IR-indexed AR write, then raddr-indexed.
        cyc(0, 27, 16'h00A5, 0, 5, 0);
        cyc(0, 0, 0, 1, 5, 0);
        cyc(0, 4, 0, 0, 5, 0);
        cyc(0, 27, 16'h005A, 0, 1, 0);
        cyc(1, 0, 0, 0, 5, 0);
        cyc(1, 4, 0, 0, 5, 0);

        // Context clear with drop-while-busy; ctx 2 must survive.
        cyc(0, 29, 16'h0002, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 27, 16'(8'h20 + i), 0, 3'(i), 0);
        cyc(0, 29, 16'h0003, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 27, 16'h00FF, 0, 3'(i), 0);
        cyc(0, 31, 16'hFFE3, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(27, (i % 2 == 0) ? 5'd27 : 5'd6, 16'h0077, 0, 3'(i), 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(27, 0, 0, 0, 3'(i), 0);
        cyc(0, 29, 16'h0002, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(27, 0, 0, 0, 3'(i), 0);

        // Reset in the middle of a clear leaves the context half cleared.
        cyc(0, 29, 16'h0003, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 27, 16'h00FF, 0, 3'(i), 0);
        cyc(0, 31, 16'h0003, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 5, 0, 0, 0, 0);
        cyc(0, 28, 16'h0001, 0, 0, 0);
        cyc(0, 29, 16'h0003, 0, 0, 0);
        for (int i = 1; i < 8; i++) cyc(27, 0, 0, 0, 3'(i), 0);

        // Simultaneous read and write of the same register.
        cyc(27, 27, 16'h003C, 0, 4, 0);
        cyc(27, 0, 0, 0, 4, 0);

        // Random phase over contexts 0..3, all entries initialised first.
        for (int c = 0; c < 4; c++) begin
            cyc(0, 29, 16'(c), 0, 0, 0);
            for (int i = 0; i < 8; i++) cyc(0, 27, 16'($urandom), 0, 3'(i), 0);
        end
        for (int n = 0; n < 2000; n++) begin
            r  = $urandom_range(0, 99);
            ra = ra_tab[$urandom_range(0, 7)];
            d  = 16'($urandom);
            if (r < 30) wa = 5'd0;
            else if (r < 55) wa = 5'(4 + $urandom_range(0, 3));
            else if (r < 70) wa = 5'd27;
            else if (r < 78) wa = 5'd28;
            else if (r < 86) wa = ($urandom_range(0, 1) == 0) ? 5'd29 : 5'd30;
            else if (r < 88) wa = 5'd31;
            else wa = 5'(8 + $urandom_range(0, 18));
            if (wa >= 5'd29) d = d & 16'hFFE3;
            if ($urandom_range(0, 19) == 0) fp_rom = ~fp_rom;
            cyc(ra, wa, d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 299) == 0));
        end

        repeat (3) @(negedge clk4);
        chk("rd_q_drain", 16'(rd_q.size()), 16'h0000);
        chk("aext_q_drain", 16'(aext_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
